// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART transmitter between two byte requesters,
// with a watchdog on the UART busy handshake.
module uart_tx_scheduler #(
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [7:0] dat0,
    input  logic [7:0] dat1,
    output logic [1:0] ack,
    output logic [1:0] grant,
    output logic       err,
    output logic       idle,
    output logic       uart_wr,
    output logic [7:0] uart_dat,
    input  logic       uart_busy
);

    localparam int CW = $clog2(BUSY_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 2);
    localparam logic [CW-1:0] CNT_MAX  = CW'(BUSY_TIMEOUT - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WRITE   = 2'd1;
    localparam logic [1:0] S_WAIT_HI = 2'd2;
    localparam logic [1:0] S_WAIT_LO = 2'd3;

    logic [1:0]    state;
    logic          last;
    logic [CW-1:0] cnt;
    logic [1:0]    elig;
    logic [1:0]    win;

    // The requester being acked this cycle still holds req; mask it.
    assign elig = req & ~ack;

    always_comb begin
        win = 2'b00;
        case (elig)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = last ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ack      <= 2'b00;
            grant    <= 2'b00;
            err      <= 1'b0;
            idle     <= 1'b1;
            uart_wr  <= 1'b0;
            uart_dat <= 8'h00;
            last     <= 1'b1;
            cnt      <= '0;
        end else begin
            ack     <= 2'b00;
            err     <= 1'b0;
            uart_wr <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!uart_busy && win != 2'b00) begin
                        grant    <= win;
                        uart_dat <= win[1] ? dat1 : dat0;
                        last     <= win[1];
                        uart_wr  <= 1'b1;
                        idle     <= 1'b0;
                        state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    cnt   <= '0;
                    state <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (uart_busy) begin
                        state <= S_WAIT_LO;
                    end else if (cnt == CNT_LAST) begin
                        // Counter lands on BUSY_TIMEOUT-1 together with err.
                        cnt   <= CNT_MAX;
                        err   <= 1'b1;
                        grant <= 2'b00;
                        idle  <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WAIT_LO: begin
                    if (!uart_busy) begin
                        ack   <= grant;
                        grant <= 2'b00;
                        idle  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    grant <= 2'b00;
                    idle  <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: single byte, contention,
// back-to-back, busy at idle, watchdog timeout and reset mid-transfer.
module tb_uart_tx_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic [7:0] dat0 = 8'h00;
    logic [7:0] dat1 = 8'h00;
    logic       uart_busy = 1'b0;
    logic [1:0] ack;
    logic [1:0] grant;
    logic       err;
    logic       idle;
    logic       uart_wr;
    logic [7:0] uart_dat;

    int n_cmp = 0;
    int n_bad = 0;
    int n_strobe = 0;

    uart_tx_scheduler #(.BUSY_TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .dat0      (dat0),
        .dat1      (dat1),
        .ack       (ack),
        .grant     (grant),
        .err       (err),
        .idle      (idle),
        .uart_wr   (uart_wr),
        .uart_dat  (uart_dat),
        .uart_busy (uart_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ack"}, {6'd0, ack}, 8'h00);
        chk({tag, "_grant"}, {6'd0, grant}, 8'h00);
        chk({tag, "_err"}, {7'd0, err}, 8'h00);
        chk({tag, "_idle"}, {7'd0, idle}, 8'h01);
        chk({tag, "_wr"}, {7'd0, uart_wr}, 8'h00);
        chk({tag, "_dat"}, uart_dat, 8'h00);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 2'b00;
        uart_busy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk_reset_vals("rst");
    endtask

    // Starts one cycle before the expected strobe; ends in the ack cycle.
    task automatic xfer(input logic [1:0] g, input logic [7:0] d,
                        input int blen, input logic [1:0] req_wr);
        tick();
        req = req_wr;
        if (uart_wr) n_strobe++;
        chk("x_wr", {7'd0, uart_wr}, 8'h01);
        chk("x_grant", {6'd0, grant}, {6'd0, g});
        chk("x_dat", uart_dat, d);
        chk("x_idle", {7'd0, idle}, 8'h00);
        tick();
        uart_busy = 1'b1;
        chk("x_hi_wr", {7'd0, uart_wr}, 8'h00);
        chk("x_hi_err", {7'd0, err}, 8'h00);
        for (int i = 0; i < blen - 1; i++) begin
            tick();
            chk("x_lo_ack", {6'd0, ack}, 8'h00);
            chk("x_lo_grant", {6'd0, grant}, {6'd0, g});
        end
        tick();
        uart_busy = 1'b0;
        chk("x_fall_ack", {6'd0, ack}, 8'h00);
        tick();
        chk("x_ack", {6'd0, ack}, {6'd0, g});
        chk("x_ack_grant", {6'd0, grant}, 8'h00);
        chk("x_ack_idle", {7'd0, idle}, 8'h01);
        chk("x_ack_err", {7'd0, err}, 8'h00);
        chk("x_ack_wr", {7'd0, uart_wr}, 8'h00);
    endtask

    initial begin
        // Single byte
        do_reset();
        req = 2'b01;
        dat0 = 8'h41;
        xfer(2'b01, 8'h41, 10, 2'b01);
        tick();
        req = 2'b00;
        chk("single_nodup", {7'd0, uart_wr}, 8'h00);
        tick();
        chk("single_idle", {7'd0, idle}, 8'h01);

        // Back-to-back, same requester
        do_reset();
        req = 2'b01;
        dat0 = 8'h10;
        xfer(2'b01, 8'h10, 3, 2'b01);
        tick();
        dat0 = 8'h11;
        chk("b2b_nodup", {7'd0, uart_wr}, 8'h00);
        xfer(2'b01, 8'h11, 2, 2'b01);
        tick();
        req = 2'b00;
        chk("b2b_nodup2", {7'd0, uart_wr}, 8'h00);

        // Contention: alternate A0,B1 x4 each
        do_reset();
        n_strobe = 0;
        req = 2'b11;
        dat0 = 8'hA0;
        dat1 = 8'hB1;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) xfer(2'b01, 8'hA0, 1 + i % 3, 2'b11);
            else xfer(2'b10, 8'hB1, 1 + i % 3, (i == 7) ? 2'b10 : 2'b11);
        end
        tick();
        req = 2'b00;
        chk("cont_stop", {7'd0, uart_wr}, 8'h00);
        tick();
        chk("cont_stop2", {7'd0, uart_wr}, 8'h00);
        chk("cont_strobes", 8'(n_strobe), 8'd8);

        // Busy at idle
        do_reset();
        uart_busy = 1'b1;
        req = 2'b10;
        dat1 = 8'hC3;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("busy_idle_wr", {7'd0, uart_wr}, 8'h00);
            chk("busy_idle_grant", {6'd0, grant}, 8'h00);
        end
        tick();
        uart_busy = 1'b0;
        chk("busy_fall_wr", {7'd0, uart_wr}, 8'h00);
        xfer(2'b10, 8'hC3, 4, 2'b10);
        tick();
        req = 2'b00;

        // Timeout, then reset in WAIT_LO of the reissued byte
        do_reset();
        req = 2'b01;
        dat0 = 8'h5A;
        tick();
        chk("to_wr", {7'd0, uart_wr}, 8'h01);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("to_wait_err", {7'd0, err}, 8'h00);
            chk("to_wait_grant", {6'd0, grant}, 8'h01);
        end
        tick();
        chk("to_err", {7'd0, err}, 8'h01);
        chk("to_grant", {6'd0, grant}, 8'h00);
        chk("to_ack", {6'd0, ack}, 8'h00);
        chk("to_idle", {7'd0, idle}, 8'h01);
        tick();
        chk("to_rewr", {7'd0, uart_wr}, 8'h01);
        chk("to_reerr", {7'd0, err}, 8'h00);
        chk("to_redat", uart_dat, 8'h5A);
        tick();
        uart_busy = 1'b1;
        tick();
        chk("mid_grant", {6'd0, grant}, 8'h01);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        uart_busy = 1'b0;
        chk_reset_vals("mid");
        xfer(2'b01, 8'h5A, 2, 2'b01);
        tick();
        req = 2'b00;
        chk("mid_done", {7'd0, uart_wr}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares the single UART transmitter between two byte requesters, for example the J1 peripheral path and a hardware message sender. It uses round-robin arbitration. For each granted byte it issues one write strobe to the UART, then follows uart_busy through its rise and fall before acknowledging the owner. A watchdog recovers the scheduler if the UART never reports busy.

Parameters:
BUSY_TIMEOUT, 16, max cycles to wait in WAIT_HI for uart_busy to rise before aborting the transfer (must be >= 2)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
req  input  2  per-requester request level; bit i is held high, with dat_i stable, until ack[i]
dat0  input  8  byte from requester 0
dat1  input  8  byte from requester 1
ack  output  2  one-cycle pulse to the owner once the UART has finished its byte
grant  output  2  one-hot current owner; 0 when IDLE
err  output  1  one-cycle pulse on watchdog timeout
idle  output  1  high when state is IDLE
uart_wr  output  1  one-cycle write strobe to the UART
uart_dat  output  8  registered byte to the UART, valid from the strobe until the next load
uart_busy  input  1  busy flag from the UART

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; ack=0, grant=0, err=0, uart_wr=0, uart_dat=0, idle=1; rr pointer last=1, so requester 0 wins first; timeout counter=0.
- Reset mid-transfer: abort immediately; no ack or err is issued for the in-flight byte; the requester's req is still high, so the byte is resent after reset.
- IDLE:
  - Arbitrate only when uart_busy=0. If the UART is busy, stay in IDLE.
  - Eligible set = req & ~ack, which masks a requester in its ack cycle.
  - One eligible requester: it wins. Both eligible: the requester != last wins.
  - On a win: set grant, load uart_dat from the winner's data, set last := winner, go to WRITE.
- WRITE: uart_wr=1 for exactly this cycle; clear counter; go to WAIT_HI.
  - Latency: req sampled high in IDLE cycle N gives uart_wr high in cycle N+1.
- WAIT_HI:
  - If uart_busy=1, go to WAIT_LO.
  - Else increment counter. When counter == BUSY_TIMEOUT-1, pulse err for 1 cycle, clear grant, go to IDLE with no ack. The still-asserted req is rearbitrated under normal round-robin rules.
- WAIT_LO: wait without limit while uart_busy=1. On uart_busy=0, pulse ack[owner] for 1 cycle (high in the first IDLE cycle), clear grant, go to IDLE.
- Requester rule: a requester drops req, or changes data and keeps req high for the next byte, in the cycle after ack. Because req is masked during the ack cycle, no duplicate send occurs.
- Only one transfer is outstanding at a time. uart_wr is never asserted outside WRITE.
- ack, err and uart_wr are mutually exclusive in any cycle.
- Counter width is $clog2(BUSY_TIMEOUT). The counter saturates and never wraps within a transfer.
- If uart_busy drops in the same cycle it rose (a 1-cycle busy), the WAIT_HI->WAIT_LO->IDLE path still applies: ack arrives 2 cycles after the busy rise.

Test Plan:
- Single byte: req=01, dat0=0x41; UART model busy for 10 cycles from the cycle after the strobe -> exactly one uart_wr, uart_dat=0x41, grant=01 during transfer, ack=01 one cycle after busy falls; no err.
- Contention: req=11 held, dat0=0xA0, dat1=0xB1, each requester re-requests 4 bytes -> uart_dat sequence alternates A0,B1,A0,B1...; each ack matches its owner; 8 strobes total.
- Back-to-back same requester: req0 stays high across ack with new data 0x10 then 0x11 -> 0x10 sent once, then 0x11 sent once; no duplicate strobe.
- Busy at idle: uart_busy=1 for 5 cycles while req=10 -> no uart_wr until the cycle after busy falls; then dat1 is sent.
- Timeout: BUSY_TIMEOUT=16, UART never raises busy, req=01 -> err pulse 16 cycles after the strobe, no ack, grant returns to 0, strobe reissued on the next IDLE cycle.
- Reset mid-transfer: assert rst in WAIT_LO -> next cycle all outputs at reset values; after rst drops with req=01, requester 0's byte is retransmitted.
